// File: rtl/bram_fifo_pkg.sv
// Shared constants and types for the BRAM-backed FIFO controller.
// Optional error flags are enabled with the BRAM_FIFO_ERR_EN macro.
package bram_fifo_pkg;

    localparam int unsigned DEF_DATAWIDTH = 8;
    localparam int unsigned DEF_ADDRWIDTH = 4;
    localparam int unsigned DEPTH         = 2 ** DEF_ADDRWIDTH;

    // Address bits plus one wrap bit
    typedef logic [DEF_ADDRWIDTH:0] ptr_t;
    // Occupancy 0..DEPTH
    typedef logic [DEF_ADDRWIDTH:0] count_t;

endpackage

// File: rtl/bram_ptr.sv
// FIFO pointer: ADDRWIDTH address bits plus a wrap bit, +1 when inc is high.
// The carry out of the address field lands in the wrap bit.
module bram_ptr
    import bram_fifo_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = DEF_ADDRWIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    output logic [ADDRWIDTH:0]   ptr
);

    logic [ADDRWIDTH:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Synchronous FIFO controller driving a simple dual-port BRAM (1-cycle read latency).
// Define BRAM_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module bram_fifo_ctrl
    import bram_fifo_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DEF_DATAWIDTH,
    parameter int unsigned ADDRWIDTH = DEF_ADDRWIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATAWIDTH-1:0]  wr_data,
    input  logic                  rd_en,
    output logic                  full,
    output logic                  empty,
    output logic [ADDRWIDTH:0]    count,
    output logic                  bram_we,
    output logic [ADDRWIDTH-1:0]  bram_waddr,
    output logic [DATAWIDTH-1:0]  bram_wdata,
    output logic                  bram_re,
    output logic [ADDRWIDTH-1:0]  bram_raddr,
    input  logic [DATAWIDTH-1:0]  bram_rdata,
    output logic [DATAWIDTH-1:0]  rd_data,
`ifdef BRAM_FIFO_ERR_EN
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic                  rd_valid
);

    logic [ADDRWIDTH:0] wr_ptr, rd_ptr;
    logic [ADDRWIDTH:0] count_q, count_d;
    logic               rd_valid_q;
    logic               wr_acc, rd_acc;

    bram_ptr #(
        .ADDRWIDTH (ADDRWIDTH)
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr_acc),
        .ptr   (wr_ptr)
    );

    bram_ptr #(
        .ADDRWIDTH (ADDRWIDTH)
    ) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rd_acc),
        .ptr   (rd_ptr)
    );

    // Flags depend only on registered pointers, never on the request inputs
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[ADDRWIDTH-1:0] == rd_ptr[ADDRWIDTH-1:0]) &&
                (wr_ptr[ADDRWIDTH] != rd_ptr[ADDRWIDTH]);
    end

    always_comb begin
        wr_acc     = wr_en & ~full;
        rd_acc     = rd_en & ~empty;
        bram_we    = wr_acc;
        bram_waddr = wr_ptr[ADDRWIDTH-1:0];
        bram_wdata = wr_data;
        bram_re    = rd_acc;
        bram_raddr = rd_ptr[ADDRWIDTH-1:0];
        rd_data    = bram_rdata;
        rd_valid   = rd_valid_q;
        count      = count_q;
    end

    always_comb begin
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rd_valid_q <= rd_acc;
        end
    end

`ifdef BRAM_FIFO_ERR_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q | (wr_en & full);
            underflow_q <= underflow_q | (rd_en & empty);
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule
